// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and the default bit period,
// which the receive path also uses.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_e;

  // 868 us per bit at 50 MHz (2 x 434 us)
  localparam int CLKS_PER_BIT_DEFAULT = 43400;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1, then wraps to 0.
// bit_tick marks the last cycle of each bit period; clr holds the count at 0.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 43400
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (clr || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign bit_tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: sends start bit, DATA_BITS data bits LSB first and STOP_BITS stop bits.
// All outputs are registered; TxD is loaded with the level of the state being entered.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 TxD,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e            r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [2:0]           r_bit_cnt, w_bit_cnt_next;
  logic                 r_txd, w_txd_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic                 w_tick;
  logic                 w_timer_clr;

  // Holding the timer clear in IDLE makes the first bit period start exactly at acceptance.
  assign w_timer_clr = (r_state == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLOCK_50(CLOCK_50),
    .Reset   (Reset),
    .clr     (w_timer_clr),
    .bit_tick(w_tick)
  );

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_txd_next     = r_txd;
    w_done_next    = 1'b0;
    case (r_state)
      IDLE: begin
        w_txd_next = 1'b1;
        if (tx_start) begin
          w_state_next   = START;
          w_shift_next   = tx_data;
          w_bit_cnt_next = '0;
          w_txd_next     = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_cnt_next = '0;
          w_txd_next     = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
          if (r_bit_cnt == LAST_DATA) begin
            w_state_next   = STOP;
            w_bit_cnt_next = '0;
            w_txd_next     = 1'b1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            w_txd_next     = r_shift[1];
          end
        end
      end
      STOP: begin
        w_txd_next = 1'b1;
        if (w_tick) begin
          if (r_bit_cnt == LAST_STOP) begin
            w_state_next   = IDLE;
            w_bit_cnt_next = '0;
            w_done_next    = 1'b1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_txd_next   = 1'b1;
      end
    endcase
    w_busy_next = (w_state_next != IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_txd     <= w_txd_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  assign TxD     = r_txd;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: instance 0 uses 16 clocks/bit with 1 stop bit, instance 1
// uses 4 clocks/bit with 2 stop bits. A frame-age model predicts every output cycle.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       Reset;
  logic       start_v [2];
  logic [7:0] data_v  [2];
  logic       txd_o   [2];
  logic       busy_o  [2];
  logic       done_o  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
    .CLOCK_50(clk), .Reset(Reset), .tx_start(start_v[0]), .tx_data(data_v[0]),
    .TxD(txd_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2)) dut1 (
    .CLOCK_50(clk), .Reset(Reset), .tx_start(start_v[1]), .tx_data(data_v[1]),
    .TxD(txd_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1])
  );

  // ---------------- behavioural model ----------------
  // age = cycles since the accepting edge (-1 when no frame). A frame of
  // (1+8+stop) bits lasts flen cycles; the cycle at age==flen is the tx_done cycle.
  function automatic int clks_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int flen(input int i);
    return (1 + 8 + ((i == 0) ? 1 : 2)) * clks_of(i);
  endfunction

  int         age   [2] = '{-1, -1};
  logic [7:0] mdata [2] = '{8'h00, 8'h00};

  function automatic logic model_bit(input int i, input int a);
    int slot;
    slot = a / clks_of(i);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return mdata[i][slot-1];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge Reset) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) age[i] <= -1;
      else if ((age[i] < 0 || age[i] == flen(i)) && start_v[i]) begin
        age[i]   <= 0;
        mdata[i] <= data_v[i];
      end
      else if (age[i] >= 0 && age[i] < flen(i)) age[i] <= age[i] + 1;
      else age[i] <= -1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : cmp
    logic e_txd, e_busy, e_done;
    for (int i = 0; i < 2; i++) begin
      e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      if (age[i] >= 0 && age[i] < flen(i)) begin
        e_busy = 1'b1;
        e_txd  = model_bit(i, age[i]);
      end else if (age[i] == flen(i)) begin
        e_done = 1'b1;
      end
      n_cmp = n_cmp + 3;
      if (txd_o[i] !== e_txd) begin
        n_bad++;
        $display("FAIL model_txd dut%0d cyc=%0d: got %b want %b", i, cyc, txd_o[i], e_txd);
      end
      if (busy_o[i] !== e_busy) begin
        n_bad++;
        $display("FAIL model_busy dut%0d cyc=%0d: got %b want %b", i, cyc, busy_o[i], e_busy);
      end
      if (done_o[i] !== e_done) begin
        n_bad++;
        $display("FAIL model_done dut%0d cyc=%0d: got %b want %b", i, cyc, done_o[i], e_done);
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic txd_rec [0:399];
  int   busy_cnt, done_cnt, done_at;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic launch(input int sel, input logic [7:0] d, input logic hold);
    @(posedge clk); #1;
    data_v[sel]  = d;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_v[sel] = 1'b0;
  endtask

  // Sample n cycles starting at age 0; optionally raise tx_start at ev_at and drop it at rel_at.
  task automatic record(input int sel, input int n, input int ev_at, input logic [7:0] ev_data,
                        input int rel_at);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      txd_rec[k] = txd_o[sel];
      if (busy_o[sel]) busy_cnt++;
      if (done_o[sel]) begin
        if (done_at < 0) done_at = k;
        done_cnt++;
      end
      if (k == ev_at) begin
        data_v[sel]  = ev_data;
        start_v[sel] = 1'b1;
      end
      if (k == rel_at) start_v[sel] = 1'b0;
    end
  endtask

  function automatic logic [15:0] slots(input int base, input int c, input int nslots);
    logic [15:0] v;
    v = '0;
    for (int s = 0; s < nslots; s++) v[s] = txd_rec[base + c*s + c/2];
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    int   idle_bad, high_cnt;
    Reset = 1'b1;
    start_v = '{1'b0, 1'b0};
    data_v  = '{8'h00, 8'h00};

    @(negedge clk);
    check("reset_outputs", {29'd0, txd_o[0], busy_o[0], done_o[0]}, 32'b100);
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;

    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) idle_bad++;
    end
    check("idle_after_reset", idle_bad, 0);

    // single byte A5
    launch(0, 8'hA5, 1'b0);
    record(0, 180, -1, 8'h00, -1);
    check("a5_slots", slots(0, 16, 10), 16'b11_0100_1010);
    check("a5_busy_cycles", busy_cnt, 160);
    check("a5_done_at", done_at, 160);
    check("a5_done_count", done_cnt, 1);

    // busy ignore: FF strobe at cycle 40 of a 3C frame
    launch(0, 8'h3C, 1'b0);
    record(0, 220, 40, 8'hFF, 41);
    check("busy_ign_slots", slots(0, 16, 10), 16'b10_0111_1000);
    check("busy_ign_busy_cycles", busy_cnt, 160);
    check("busy_ign_done_count", done_cnt, 1);

    // back-to-back: 00 then 81 with tx_start held
    launch(0, 8'h00, 1'b1);
    record(0, 340, 0, 8'h81, 200);
    check("b2b_slots_first", slots(0, 16, 10), 16'b10_0000_0000);
    check("b2b_slots_second", slots(161, 16, 10), 16'b11_0000_0010);
    check("b2b_done_at", done_at, 160);
    check("b2b_gap", {30'd0, txd_rec[160], txd_rec[161]}, 32'b10);
    check("b2b_busy_cycles", busy_cnt, 320);
    check("b2b_done_count", done_cnt, 2);

    // mid-frame reset at cycle 70 of a 00 frame
    launch(0, 8'h00, 1'b0);
    record(0, 70, -1, 8'h00, -1);
    @(posedge clk); #1 Reset = 1'b1;
    #1;
    check("midrst_txd_immediate", {31'd0, txd_o[0]}, 32'd1);
    check("midrst_busy_immediate", {31'd0, busy_o[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    record(0, 30, -1, 8'h00, -1);
    check("midrst_no_done", done_cnt, 0);
    launch(0, 8'h00, 1'b0);
    record(0, 170, -1, 8'h00, -1);
    check("midrst_clean_slots", slots(0, 16, 10), 16'b10_0000_0000);
    check("midrst_clean_busy", busy_cnt, 160);
    check("midrst_clean_done_at", done_at, 160);

    // two stop bits on instance 1: 4 clocks/bit, data 55
    launch(1, 8'h55, 1'b0);
    record(1, 60, -1, 8'h00, -1);
    check("stop2_slots", slots(0, 4, 11), 16'b110_1010_1010);
    high_cnt = 0;
    for (int k = 32; k < 44; k++) if (txd_rec[k] === 1'b1) high_cnt++;
    check("stop2_stop_high_cycles", high_cnt, 8);
    check("stop2_busy_cycles", busy_cnt, 44);
    check("stop2_done_at", done_at, 44);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
